// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared constants and types for the final_adder chain (stage_3 and its
// fix_to_float converter).
//   CORDIC_DATA_WIDTH : default width of a signed Q2.(W-2) CORDIC result
//   FRAC_BITS         : fractional bits of that result
//   FLOAT_BIAS        : IEEE-754 single-precision exponent bias
//   FLOAT_WIDTH       : IEEE-754 single width
//   state_t           : pairing FSM states
// -----------------------------------------------------------------------------
package cordic_pkg;

   localparam int CORDIC_DATA_WIDTH = 22;
   localparam int FRAC_BITS         = CORDIC_DATA_WIDTH - 2;
   localparam int FLOAT_BIAS        = 127;
   localparam int FLOAT_WIDTH       = 32;

   typedef enum logic [0:0] {
      WAIT_A = 1'b0,
      HOLD_B = 1'b1
   } state_t;

endpackage : cordic_pkg

// File: rtl/fix_to_float.sv
// -----------------------------------------------------------------------------
// fix_to_float
// Combinational conversion of a signed fixed-point value with FRAC_W fractional
// bits into an IEEE-754 single. Exact for IN_W <= 24 (no rounding needed).
// Zero always converts to +0.0.
// Configuration macro: STAGE3_AVERAGE_EN -- when defined the result is halved
// (exponent reduced by one after normalisation); zero still gives +0.0.
// Ports:
//   sum_in    in  IN_W  signed fixed-point value
//   float_out out 32    IEEE-754 single encoding of sum_in (or sum_in/2)
// -----------------------------------------------------------------------------
module fix_to_float
   import cordic_pkg::*;
#(
   parameter int IN_W   = CORDIC_DATA_WIDTH + 1,
   parameter int FRAC_W = FRAC_BITS
) (
   input  logic [IN_W-1:0] sum_in,
   output logic [31:0]     float_out
);

   localparam int PW = $clog2(IN_W);

`ifdef STAGE3_AVERAGE_EN
   localparam int EXP_ADJ = 1;
`else
   localparam int EXP_ADJ = 0;
`endif

   logic              sign_s;
   logic [IN_W-1:0]   mag_s;
   logic [PW-1:0]     lead_s;
   logic [IN_W-1:0]   norm_s;
   logic [IN_W+21:0]  ext_s;
   logic [22:0]       mant_s;
   logic [7:0]        exp_s;
   logic              zero_s;

   // Magnitude, leading-one detect, normalise and pack
   always_comb begin
      sign_s = sum_in[IN_W-1];
      // the most negative input gives a magnitude with only the top bit set,
      // which still fits because mag_s keeps the full input width
      if (sign_s) begin
         mag_s = IN_W'(~sum_in) + IN_W'(1'b1);
      end else begin
         mag_s = sum_in;
      end

      // highest set bit wins because later iterations overwrite earlier ones
      lead_s = {PW{1'b0}};
      for (int i = 0; i < IN_W; i++) begin
         if (mag_s[i]) begin
            lead_s = PW'(i);
         end else begin
            lead_s = lead_s;
         end
      end

      // move the leading one to the top bit, then drop it (hidden bit)
      norm_s = mag_s << (PW'(IN_W - 1) - lead_s);
      ext_s  = {norm_s[IN_W-2:0], 23'd0};
      mant_s = ext_s[IN_W+21 -: 23];
      exp_s  = 8'(FLOAT_BIAS - FRAC_W - EXP_ADJ) + 8'(lead_s);
      zero_s = (mag_s == {IN_W{1'b0}});

      if (zero_s) begin
         float_out = 32'h0000_0000;
      end else begin
         float_out = {sign_s, exp_s, mant_s};
      end
   end

endmodule : fix_to_float

// File: rtl/stage_3.sv
// -----------------------------------------------------------------------------
// stage_3
// Final stage of the final_adder chain. Pairs consecutive CORDIC results
// (A then B), adds them exactly, converts the sum to IEEE-754 single and
// presents it two cycles after B with a one-cycle sum_valid strobe. The
// squared_in float sampled with B travels alongside and leaves as squared_out.
// An A left waiting when stage_2 reports its pipeline cleared is dropped with
// a one-cycle orphan_err strobe.
// Configuration macro: STAGE3_AVERAGE_EN (in fix_to_float) -- output is the
// average (A+B)/2 instead of the sum; timing and handshake unchanged.
// Ports:
//   clk              in   1   rising-edge clock
//   rst              in   1   asynchronous active-low reset
//   clk_en           in   1   global enable; low holds every flop
//   result_in        in   W   signed Q2.(W-2) CORDIC result
//   valid_in         in   1   result_in / squared_in valid
//   squared_in       in   32  float from stage_2, captured with B
//   pipeline_cleared in   1   stage_2 pipeline empty
//   sum_out          out  32  float(A+B) (or average)
//   squared_out      out  32  squared_in captured with B, aligned to sum_out
//   sum_valid        out  1   one-cycle strobe for sum_out/squared_out
//   orphan_err       out  1   one-cycle strobe, pending A abandoned
//   pair_count       out  16  completed pairs since reset, wrapping
// -----------------------------------------------------------------------------
module stage_3 #(
   parameter int CORDIC_DATA_WIDTH = 22,
   parameter int FLOAT_DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH       = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk_en,
   input  logic [CORDIC_DATA_WIDTH-1:0] result_in,
   input  logic                         valid_in,
   input  logic [FLOAT_DATA_WIDTH-1:0]  squared_in,
   input  logic                         pipeline_cleared,
   output logic [FLOAT_DATA_WIDTH-1:0]  sum_out,
   output logic [FLOAT_DATA_WIDTH-1:0]  squared_out,
   output logic                         sum_valid,
   output logic                         orphan_err,
   output logic [COUNT_WIDTH-1:0]       pair_count
);

   import cordic_pkg::*;

   localparam int W = CORDIC_DATA_WIDTH;

   state_t                       state_q, state_d;
   logic [W-1:0]                 a_q, a_d;
   logic [W:0]                   sum_q, sum_d;
   logic [FLOAT_DATA_WIDTH-1:0]  sq1_q, sq1_d;
   logic                         v1_q, v1_d;
   logic [FLOAT_DATA_WIDTH-1:0]  flt2_q, flt2_d;
   logic [FLOAT_DATA_WIDTH-1:0]  sq2_q, sq2_d;
   logic                         v2_q, v2_d;
   logic [FLOAT_DATA_WIDTH-1:0]  sum_out_q, sum_out_d;
   logic [FLOAT_DATA_WIDTH-1:0]  squared_out_q, squared_out_d;
   logic                         sum_valid_q, sum_valid_d;
   logic                         orphan_err_q, orphan_err_d;
   logic [COUNT_WIDTH-1:0]       pair_count_q, pair_count_d;
   logic [31:0]                  flt_s;

   fix_to_float #(
      .IN_W   (W + 1),
      .FRAC_W (W - 2)
   ) u_fix_to_float (
      .sum_in    (sum_q),
      .float_out (flt_s)
   );

   // Pairing FSM: capture A, then B; form the exact W+1-bit sum
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      sum_d        = sum_q;
      sq1_d        = sq1_q;
      v1_d         = v1_q;
      orphan_err_d = orphan_err_q;
      if (clk_en) begin
         v1_d         = 1'b0;
         orphan_err_d = 1'b0;
         case (state_q)
            WAIT_A: begin
               if (valid_in) begin
                  a_d     = result_in;
                  state_d = HOLD_B;
               end else begin
                  state_d = WAIT_A;
               end
            end
            HOLD_B: begin
               // a real B beats a simultaneous pipeline_cleared
               if (valid_in) begin
                  sum_d   = {a_q[W-1], a_q} + {result_in[W-1], result_in};
                  sq1_d   = squared_in;
                  v1_d    = 1'b1;
                  state_d = WAIT_A;
               end else if (pipeline_cleared) begin
                  orphan_err_d = 1'b1;
                  state_d      = WAIT_A;
               end else begin
                  state_d = HOLD_B;
               end
            end
            default: begin
               state_d = WAIT_A;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Convert register, output register and pair counter
   always_comb begin
      flt2_d        = flt2_q;
      sq2_d         = sq2_q;
      v2_d          = v2_q;
      sum_out_d     = sum_out_q;
      squared_out_d = squared_out_q;
      sum_valid_d   = sum_valid_q;
      pair_count_d  = pair_count_q;
      if (clk_en) begin
         v2_d         = v1_q;
         sum_valid_d  = v2_q;
         pair_count_d = pair_count_q + COUNT_WIDTH'(v2_q);
         if (v1_q) begin
            flt2_d = flt_s;
            sq2_d  = sq1_q;
         end else begin
            flt2_d = flt2_q;
            sq2_d  = sq2_q;
         end
         if (v2_q) begin
            sum_out_d     = flt2_q;
            squared_out_d = sq2_q;
         end else begin
            sum_out_d     = sum_out_q;
            squared_out_d = squared_out_q;
         end
      end else begin
         v2_d = v2_q;
      end
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= WAIT_A;
         a_q           <= {W{1'b0}};
         sum_q         <= {(W+1){1'b0}};
         sq1_q         <= {FLOAT_DATA_WIDTH{1'b0}};
         v1_q          <= 1'b0;
         flt2_q        <= {FLOAT_DATA_WIDTH{1'b0}};
         sq2_q         <= {FLOAT_DATA_WIDTH{1'b0}};
         v2_q          <= 1'b0;
         sum_out_q     <= {FLOAT_DATA_WIDTH{1'b0}};
         squared_out_q <= {FLOAT_DATA_WIDTH{1'b0}};
         sum_valid_q   <= 1'b0;
         orphan_err_q  <= 1'b0;
         pair_count_q  <= {COUNT_WIDTH{1'b0}};
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         sum_q         <= sum_d;
         sq1_q         <= sq1_d;
         v1_q          <= v1_d;
         flt2_q        <= flt2_d;
         sq2_q         <= sq2_d;
         v2_q          <= v2_d;
         sum_out_q     <= sum_out_d;
         squared_out_q <= squared_out_d;
         sum_valid_q   <= sum_valid_d;
         orphan_err_q  <= orphan_err_d;
         pair_count_q  <= pair_count_d;
      end
   end

   assign sum_out     = sum_out_q;
   assign squared_out = squared_out_q;
   assign sum_valid   = sum_valid_q;
   assign orphan_err  = orphan_err_q;
   assign pair_count  = pair_count_q;

endmodule : stage_3
